// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: dispense phases, the job record
// and small helpers that classify a job.
package vend_pkg;

  localparam int JOB_CNT_W    = 3;
  localparam int NICKEL_CENTS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VEND  = 2'd1,
    EJECT = 2'd2,
    GAP   = 2'd3
  } disp_state_e;

  typedef struct packed {
    logic                 soda;
    logic [JOB_CNT_W-1:0] count;
  } job_t;

  function automatic logic is_request(input job_t j);
    return j.soda || (j.count != {JOB_CNT_W{1'b0}});
  endfunction

  // A job with a soda always vends first; change-only jobs start ejecting.
  function automatic disp_state_e start_state(input job_t j);
    return j.soda ? VEND : EJECT;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/actuator bundle between the soda FSM side and the dispenser.
interface change_dispenser_if
  import vend_pkg::*;
#(
  parameter int CNT_W = JOB_CNT_W
);
  logic             soda_i;
  logic [CNT_W-1:0] change_i;
  logic             vend_o;
  logic             nickel_o;
  logic             busy_o;
  logic             pend_o;
  logic             drop_o;
  logic [CNT_W-1:0] nickels_left_o;

  modport master (
    output soda_i, change_i,
    input  vend_o, nickel_o, busy_o, pend_o, drop_o, nickels_left_o
  );

  modport slave (
    input  soda_i, change_i,
    output vend_o, nickel_o, busy_o, pend_o, drop_o, nickels_left_o
  );
endinterface

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter used to time both actuator pulses and the gaps
// between them; done_o is high once the count has reached zero.
module pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// Turns one-cycle vend/change requests into a timed vend pulse followed by a
// train of single-nickel pulses, with a one-deep pending slot for overlap.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  change_dispenser_if.slave  bus
);

  localparam int TW = 8;

  disp_state_e          state_q, state_d;
  job_t                 req_s;
  job_t                 pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [JOB_CNT_W-1:0] left_q, left_d;
  logic                 vend_q, nickel_q, busy_q, drop_q, drop_d;
  logic                 req_vld_s, done_s, gap_end_s, tmr_load_s;
  logic [TW-1:0]        tmr_val_s;

  assign req_s     = '{soda: bus.soda_i, count: bus.change_i};
  assign req_vld_s = is_request(req_s);
  // last GAP cycle of a job whose nickels are all out: the active slot frees up
  assign gap_end_s = (state_q == GAP) && done_s && (left_q == {JOB_CNT_W{1'b0}});

  // next-state, active-job and pending-slot logic
  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_vld_s) begin
          state_d = start_state(req_s);
          left_d  = req_s.count;
        end else begin
          state_d = IDLE;
        end
      end
      VEND: begin
        if (done_s) begin
          state_d = GAP;
        end else begin
          state_d = VEND;
        end
      end
      EJECT: begin
        if (done_s) begin
          state_d = GAP;
          if (left_q != {JOB_CNT_W{1'b0}}) begin
            left_d = left_q - JOB_CNT_W'(1);
          end else begin
            left_d = left_q;
          end
        end else begin
          state_d = EJECT;
        end
      end
      GAP: begin
        if (!done_s) begin
          state_d = GAP;
        end else if (left_q != {JOB_CNT_W{1'b0}}) begin
          state_d = EJECT;
        end else if (pend_vld_q) begin
          state_d    = start_state(pend_q);
          left_d     = pend_q.count;
          pend_vld_d = 1'b0;
        end else if (req_vld_s) begin
          state_d = start_state(req_s);
          left_d  = req_s.count;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        left_d  = {JOB_CNT_W{1'b0}};
      end
    endcase

    // requests arriving while busy go to the pending slot, or are dropped
    if (req_vld_s && (state_q != IDLE)) begin
      if (gap_end_s) begin
        if (pend_vld_q) begin
          pend_d     = req_s;
          pend_vld_d = 1'b1;
        end else begin
          drop_d = 1'b0;
        end
      end else if (!pend_vld_q) begin
        pend_d     = req_s;
        pend_vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end
  end

  assign tmr_load_s = (state_d != state_q) && (state_d != IDLE);
  assign tmr_val_s  = (state_d == GAP) ? TW'(GAP_LEN - 1) : TW'(PULSE_LEN - 1);

  pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load_s),
    .value_i (tmr_val_s),
    .done_o  (done_s)
  );

  // state, job registers and registered actuator/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      left_q     <= {JOB_CNT_W{1'b0}};
      pend_q     <= '{soda: 1'b0, count: {JOB_CNT_W{1'b0}}};
      pend_vld_q <= 1'b0;
      vend_q     <= 1'b0;
      nickel_q   <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      vend_q     <= (state_d == VEND);
      nickel_q   <= (state_d == EJECT);
      busy_q     <= (state_d != IDLE);
      drop_q     <= drop_d;
    end
  end

  assign bus.vend_o         = vend_q;
  assign bus.nickel_o       = nickel_q;
  assign bus.busy_o         = busy_q;
  assign bus.pend_o         = pend_vld_q;
  assign bus.drop_o         = drop_q;
  assign bus.nickels_left_o = left_q;

endmodule
